// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the bit-serial two's-complement unit.
// Defines the per-word operation encoding and the counter width helper.
package serial_comp_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_NEG  = 2'd1,
    MODE_ABS  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// Serial two's-complement negate cell: copies bits up to and including the
// first 1, inverts every bit after it. Acts as a pass-through when neg is low.
module serial_negate_cell (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  input  logic neg,
  input  logic in_bit,
  output logic out_bit
);

  logic seen_one;

  // start wins over en so a word loaded on the final bit of the previous one
  // begins with a clean history
  always_ff @(posedge clk) begin
    if (rst || start) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_one | in_bit;
    end
  end

  assign out_bit = in_bit ^ (neg & seen_one);

endmodule

// File: rtl/serial_twos_comp.sv
// Bit-serial pass / negate / abs unit with word framing and overflow flag.
// Captures LSB-first words, then replays each one through the negate cell.
module serial_twos_comp
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic [1:0] mode,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       ovf
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic eff_negate(input mode_e m, input logic sign);
    return (m == MODE_NEG) || ((m == MODE_ABS) && sign);
  endfunction

  function automatic logic is_most_neg(input logic [WIDTH-1:0] w);
    return w == MOST_NEG;
  endfunction

  // ---- stage p0: serial capture ----
  logic [CW-1:0]    cnt_p0;
  logic [WIDTH-2:0] cap_p0;
  mode_e            mode_p0;
  logic             done_p0;
  logic [WIDTH-1:0] word_p0;

  assign done_p0 = in_valid && (cnt_p0 == LAST_IDX);
  assign word_p0 = {in_bit, cap_p0};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0  <= '0;
      mode_p0 <= MODE_PASS;
    end else if (in_valid) begin
      cnt_p0 <= (cnt_p0 == LAST_IDX) ? '0 : cnt_p0 + CW'(1);
      if (cnt_p0 == '0) begin
        mode_p0 <= mode_e'(mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      cap_p0 <= word_p0[WIDTH-1:1];
    end
  end

  // ---- stage p1: word emission ----
  logic [WIDTH-1:0] emt_p1;
  logic [CW-1:0]    idx_p1;
  logic             vld_p1;
  logic             neg_p1;
  logic             ovfw_p1;
  logic             cell_bit_p1;
  logic             last_p1;

  // the sign bit is the final accepted bit, i.e. in_bit on the completing edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      idx_p1  <= '0;
      neg_p1  <= 1'b0;
      ovfw_p1 <= 1'b0;
    end else if (done_p0) begin
      vld_p1  <= 1'b1;
      idx_p1  <= '0;
      neg_p1  <= eff_negate(mode_p0, in_bit);
      ovfw_p1 <= eff_negate(mode_p0, in_bit) && is_most_neg(word_p0);
    end else if (vld_p1) begin
      if (idx_p1 == LAST_IDX) begin
        vld_p1 <= 1'b0;
      end else begin
        idx_p1 <= idx_p1 + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done_p0) begin
      emt_p1 <= word_p0;
    end
  end

  serial_negate_cell u_neg (
    .clk     (clk),
    .rst     (rst),
    .start   (done_p0),
    .en      (vld_p1),
    .neg     (neg_p1),
    .in_bit  (emt_p1[idx_p1]),
    .out_bit (cell_bit_p1)
  );

  assign last_p1   = vld_p1 && (idx_p1 == LAST_IDX);
  assign out_valid = vld_p1;
  assign out_bit   = vld_p1 & cell_bit_p1;
  assign out_last  = last_p1;
  assign ovf       = last_p1 & ovfw_p1;

endmodule

// File: doc/serial_twos_comp.md
# serial_twos_comp

Parametrised bit-serial two's-complement unit: accepts LSB-first serial words of `WIDTH` bits, and re-emits each word as a serial stream with a per-word operation applied: pass, negate or absolute value. An overflow flag is raised for the one unrepresentable result. It sits between a serial source (shift-out of a sample register or a serial link) and downstream serial arithmetic. It generalises the single-stream negate cell with word framing, a mode select, a fixed-latency word buffer and overflow detection.

## Interface
- `WIDTH`, default 8: bits per word; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  qualifies `in_bit`; gaps allowed anywhere inside a word.
- `in_bit`  in  1  serial data, LSB first.
- `mode`  in  2  0 = pass, 1 = negate, 2 = abs, 3 = reserved (behaves as pass); sampled on the word's bit 0.
- `out_valid`  out  1  qualifies `out_bit`.
- `out_bit`  out  1  serial result, LSB first.
- `out_last`  out  1  high with the MSB (bit `WIDTH-1`) of each result word.
- `ovf`  out  1  high with `out_last` when negate or abs is applied to the most negative value.

## Operation
- Capture side:
  - Bit counter `cnt` (0..`WIDTH-1`) advances only on `in_valid`, wrapping from `WIDTH-1` to 0.
  - Accepted bits shift into capture register `cap`.
  - `mode` is latched when `cnt == 0 && in_valid`; later `mode` changes within the word are ignored.
- Word complete (`in_valid && cnt == WIDTH-1`): at that edge, the full word, the latched mode and the sign bit (= last accepted bit) transfer into emit register `emt`. The emitter starts with `seen_one = 0` and `idx = 0`.
- Emit side: one bit per cycle for exactly `WIDTH` consecutive cycles, no backpressure.
  - Effective negate `neg` = (mode == negate) or (mode == abs and sign == 1).
  - `neg == 0`: `out_bit = b[idx]`.
  - `neg == 1`: `out_bit = b[idx] ^ seen_one`, then `seen_one |= b[idx]` (copy up to and including the first 1, invert thereafter).
- `ovf`: `neg == 1` and word == 1 followed by `WIDTH-1` zeros, i.e. −2^(WIDTH−1). The result equals the input (−2^(WIDTH−1) again) and `ovf = 1` on that word's `out_last` cycle only.
- Zero input under negate/abs gives zero, `ovf = 0`.
- Reset values: `out_valid = 0`, `out_bit = 0`, `out_last = 0`, `ovf = 0`, `cnt = 0`, `seen_one = 0`. Any partial captured word and any word in emission is discarded.

## Timing
- Last input bit accepted in cycle t → result bit 0 on `out_bit` in cycle t+1 and MSB with `out_last` in cycle t+`WIDTH`. Latency is fixed regardless of `in_valid` gaps earlier in the word.
- Back-to-back words (`in_valid` held high): the next word completes no earlier than t+`WIDTH`, so its emission starts at t+`WIDTH`+1. `out_valid` stays continuous and capture never stalls; no ready signal is required.
- `in_valid` gaps stretch capture only; emission is never interrupted.
- `rst` high in any cycle: all outputs are 0 from the next cycle. The first bit accepted after reset release is bit 0 of a new word.
- `out_valid = 0` ⇒ `out_bit`, `out_last` and `ovf` are all driven 0.

## Structure
- Package `serial_comp_pkg`:
  - `mode_e` enum (`MODE_PASS`, `MODE_NEG`, `MODE_ABS`, `MODE_RSVD`).
  - Default width constant.
  - Function computing the counter width as `$clog2(WIDTH)`.
- Sub-module `serial_negate_cell`: the `seen_one` flop plus XOR, with `clk`, `rst`, `start` (clears `seen_one`), `en`, `neg`, `in_bit`, `out_bit`. Instantiated once in the emit path.
- Top level holds the capture counter/shift register, the emit register/index, and the overflow compare.

## Test plan
- `WIDTH` = 8, negate: 0x06 (bits 0,1,1,0,0,0,0,0) → 0xFA (0,1,0,1,1,1,1,1), first bit at t+1, `out_last` at t+8, `ovf` = 0.
- Abs mode, 0xF3 (−13) → 0x0D; abs of 0x2C → 0x2C unchanged; pass of 0xA5 → 0xA5.
- Negate 0x80 and abs 0x80 → 0x80 with `ovf` = 1 on `out_last` only; negate 0x00 → 0x00, `ovf` = 0.
- Three back-to-back words with `in_valid` held high → `out_valid` high for 24 consecutive cycles, `out_last` every 8th. Toggling `mode` mid-word has no effect on that word.
- Random `in_valid` gaps inside words → identical results with latency measured from the last accepted bit.
- `rst` asserted after 4 bits of a word and again mid-emission → outputs 0 the next cycle; the following 8 accepted bits form a fresh word.
